// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data bus between the load/store unit and memory
interface load_store_unit_if;

    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    // Load/store unit side: issues requests, receives acknowledge and read data.
    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_be_o,
        output mem_wdata_o,
        input  mem_ack_i,
        input  mem_rdata_i
    );

    // Memory side: sees requests, returns acknowledge and read data.
    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_be_o,
        input  mem_wdata_o,
        output mem_ack_i,
        output mem_rdata_i
    );

endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage with single-outstanding data bus
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    is_store_i,
    input  logic [1:0]              size_i,
    input  logic                    unsigned_i,
    input  logic [31:0]             address_i,
    input  logic [31:0]             store_data_i,
    load_store_unit_if.master       bus,
    output logic [31:0]             load_data_o,
    output logic                    done_o,
    output logic                    misaligned_o,
    output logic                    bus_err_o,
    output logic                    stall_o
);

    // Counter value on the last REQ cycle before the access is abandoned.
    localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        w_legal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_enter_req;
    logic        w_finish_mis;
    logic        w_finish_ack;
    logic        w_finish_to;

    logic        r_we;
    logic [29:0] r_word_addr;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [15:0] r_cnt;
    logic [31:0] r_load_data;
    logic        r_misaligned;
    logic        r_bus_err;

    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;
    logic [31:0] w_load_fmt;

    // Legality, byte-lane enables and lane-replicated write data for the incoming access.
    always_comb begin
        w_legal = 1'b0;
        w_be    = 4'b1111;
        w_wdata = store_data_i;
        case (size_i)
            2'b00: begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << address_i[1:0];
                w_wdata = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                w_legal = ~address_i[0];
                w_be    = address_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{store_data_i[15:0]}};
            end
            2'b10: begin
                w_legal = (address_i[1:0] == 2'b00);
                w_be    = 4'b1111;
                w_wdata = store_data_i;
            end
            default: begin
                w_legal = 1'b0;
                w_be    = 4'b1111;
                w_wdata = store_data_i;
            end
        endcase
    end

    // State register; reset while a request is out simply abandons it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and the completion cause that goes with each transition into DONE.
    always_comb begin
        w_next       = r_state;
        w_enter_req  = 1'b0;
        w_finish_mis = 1'b0;
        w_finish_ack = 1'b0;
        w_finish_to  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (w_legal) begin
                        w_next      = ST_REQ;
                        w_enter_req = 1'b1;
                    end else begin
                        w_next       = ST_DONE;
                        w_finish_mis = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                // An ack on the final timeout cycle still counts as a normal completion.
                if (bus.mem_ack_i) begin
                    w_next       = ST_DONE;
                    w_finish_ack = 1'b1;
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_next      = ST_DONE;
                    w_finish_to = 1'b1;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Extract and extend the addressed lane of the read word.
    always_comb begin
        w_rd_byte  = bus.mem_rdata_i[{r_off, 3'b000} +: 8];
        w_rd_half  = r_off[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
        w_load_fmt = bus.mem_rdata_i;
        case (r_size)
            2'b00:   w_load_fmt = r_unsigned ? {24'd0, w_rd_byte}
                                             : {{24{w_rd_byte[7]}}, w_rd_byte};
            2'b01:   w_load_fmt = r_unsigned ? {16'd0, w_rd_half}
                                             : {{16{w_rd_half[15]}}, w_rd_half};
            default: w_load_fmt = bus.mem_rdata_i;
        endcase
    end

    // Latch the access on entry to REQ, count REQ cycles, record the completion result.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_we         <= 1'b0;
            r_word_addr  <= 30'd0;
            r_off        <= 2'b00;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_be         <= 4'b0000;
            r_wdata      <= 32'd0;
            r_cnt        <= 16'd0;
            r_load_data  <= 32'd0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            if (w_enter_req) begin
                r_we        <= is_store_i;
                r_word_addr <= address_i[31:2];
                r_off       <= address_i[1:0];
                r_size      <= size_i;
                r_unsigned  <= unsigned_i;
                r_be        <= w_be;
                r_wdata     <= w_wdata;
                r_cnt       <= 16'd0;
            end else if (r_state == ST_REQ) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (w_finish_mis) begin
                r_misaligned <= 1'b1;
                r_bus_err    <= 1'b0;
                r_load_data  <= 32'd0;
            end else if (w_finish_to) begin
                r_misaligned <= 1'b0;
                r_bus_err    <= 1'b1;
                r_load_data  <= 32'd0;
            end else if (w_finish_ack) begin
                r_misaligned <= 1'b0;
                r_bus_err    <= 1'b0;
                r_load_data  <= r_we ? 32'd0 : w_load_fmt;
            end else if (r_state == ST_DONE) begin
                r_misaligned <= 1'b0;
                r_bus_err    <= 1'b0;
            end
        end
    end

    // Bus outputs are only driven while a request is outstanding.
    always_comb begin
        bus.mem_req_o   = (r_state == ST_REQ);
        bus.mem_we_o    = bus.mem_req_o & r_we;
        bus.mem_addr_o  = bus.mem_req_o ? {r_word_addr, 2'b00} : 32'd0;
        bus.mem_be_o    = bus.mem_req_o ? r_be : 4'b0000;
        bus.mem_wdata_o = bus.mem_req_o ? r_wdata : 32'd0;
    end

    // Core-facing status.
    always_comb begin
        load_data_o  = r_load_data;
        done_o       = (r_state == ST_DONE);
        misaligned_o = r_misaligned;
        bus_err_o    = r_bus_err;
        stall_o      = (r_state == ST_REQ) | ((r_state == ST_IDLE) & start_i);
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the execute stage.
- Inputs: effective address (execute address output), store data (rs2 value) and access type for the current load/store.
- Drives a single-outstanding request/acknowledge data bus with word-aligned address and byte enables.
- Returns sign/zero-extended load data for writeback and stalls the core FSM while the access is in flight.
- Detects misaligned/illegal accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 64, cycles in REQ without mem_ack_i before abort with bus error (legal range 2..65535)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_ni  input  1  synchronous active-low reset
start_i  input  1  one-cycle pulse: begin access (core in memory state)
is_store_i  input  1  1 = store, 0 = load
size_i  input  2  00 byte, 01 halfword, 10 word, 11 reserved
unsigned_i  input  1  loads only: 1 = zero-extend (LBU/LHU), 0 = sign-extend
address_i  input  32  effective byte address
store_data_i  input  32  store value, low bits significant
mem_req_o  output  1  bus request, held until ack or timeout
mem_we_o  output  1  write enable, valid with mem_req_o
mem_addr_o  output  32  {address[31:2],2'b00}
mem_be_o  output  4  byte enables
mem_wdata_o  output  32  lane-replicated store data
mem_ack_i  input  1  bus acknowledge; rdata valid same cycle
mem_rdata_i  input  32  read word
load_data_o  output  32  formatted load result, held until next completion
done_o  output  1  one-cycle completion pulse
misaligned_o  output  1  valid with done_o: misaligned or reserved size
bus_err_o  output  1  valid with done_o: timeout
stall_o  output  1  core must hold state

Behaviour:
- Reset (rst_ni low at edge):
  - State IDLE; all outputs 0, including load_data_o and flags.
  - Reset during REQ drops mem_req_o at that edge. No done_o is generated.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - start_i with a legal, aligned access: latch type/address/data and go to REQ. mem_req_o is asserted (registered) from the next cycle.
  - start_i with an illegal access (halfword with addr[0]=1, word with addr[1:0]!=0, or size 11): no bus request; go to DONE with misaligned_o=1 and load_data_o=0.
- REQ:
  - mem_req_o/we/addr/be/wdata are stable every cycle until exit.
  - mem_ack_i=1: capture formatted data (loads only; stores leave load_data_o=0) and go to DONE. mem_req_o is low in the DONE cycle.
  - Timeout: cycle counter starts at 0 on REQ entry. If the counter reaches TIMEOUT_CYCLES-1 with no ack, go to DONE with bus_err_o=1 and load_data_o=0.
  - An ack in the same cycle as the timeout wins: normal completion, no error.
- DONE: done_o=1 and flags valid for exactly this cycle; then IDLE. Flags clear on return to IDLE.
- start_i outside IDLE is ignored.
- stall_o = (state==REQ) | (state==IDLE & start_i). It is low in DONE.
- Byte enables:
  - byte: 4'b0001<<addr[1:0].
  - half: addr[1]? 1100 : 0011.
  - word: 1111.
  - mem_we_o=is_store_i; loads drive be the same way.
- mem_wdata_o:
  - byte: {4{d[7:0]}}.
  - half: {2{d[15:0]}}.
  - word: d.
- Load extraction:
  - Select lane by addr[1:0] (byte) or addr[1] (half).
  - Extend to 32 bits per unsigned_i. Word loads ignore unsigned_i.
- Latency with ack on the first REQ cycle: start at cycle N, req N+1, ack N+1, done N+2.

Test Plan:
- SW addr 0x00001000, data 0xDEADBEEF, ack 2 cycles after req -> be=1111, we=1, addr 0x00001000, wdata 0xDEADBEEF; done_o exactly 1 cycle after ack; stall_o high from start to ack; load_data_o=0.
- LB addr 0x00001003, rdata 0x80FF0000 -> be=1000, load_data_o 0xFFFFFF80. Repeat with unsigned_i=1 -> 0x00000080.
- SH addr 0x00001002, data 0x00001234 -> be=1100, wdata 0x12341234. LH addr 0x00001002, rdata 0x8001xxxx -> 0xFFFF8001.
- LW addr 0x00001001, and size 11 -> no mem_req_o ever; done_o one cycle after start with misaligned_o=1, load_data_o=0.
- LW with ack never asserted, TIMEOUT_CYCLES=64 -> mem_req_o high exactly 64 cycles, then done_o with bus_err_o=1. Separately, ack on the 64th cycle -> normal completion, no error.
- rst_ni low during REQ -> mem_req_o 0 after that edge, no done_o. A later start_i runs normally. A start_i pulse during REQ is ignored.
